spi_host_arbiter: RTL and testbench
===================================

# spi_host_arbiter

Parametrised pad arbiter that lets NUM_HOSTS SPI host controllers share one set of SPI flash pads. It generalises the fixed two-way memory-mapped/register SPI multiplexer into an N-way selector with a safe, glitch-free handover state machine. On a handover it waits until the current host's chip selects have been idle for a guard period, then parks the pads for one cycle before the new host takes over. It sits between the SPI host instances and the pad ring, and also routes each host's interrupt and DMA strobes.

## Interface
- NUM_HOSTS, 2, number of SPI host controllers (>=2)
- NUM_CS, 2, chip selects per host
- SD_W, 4, data lines (quad SPI)
- IDLE_CYCLES, 4, consecutive all-CSB-high cycles required before handover (>=1)
- RESET_HOST, 0, host selected out of reset (<NUM_HOSTS)
- IDX_W, $clog2(NUM_HOSTS), select index width
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- sel_valid_i  in  1  handover request valid
- sel_idx_i  in  IDX_W  requested host index
- sel_ready_o  out  1  request accepted when high together with sel_valid_i
- sel_err_o  out  1  one-cycle pulse: accepted request with sel_idx_i >= NUM_HOSTS
- active_idx_o  out  IDX_W  host currently owning the pads
- switching_o  out  1  high in DRAIN and PARK
- switch_done_o  out  1  one-cycle pulse: first cycle of the new host's ownership
- host_sck_i, host_sck_en_i  in  NUM_HOSTS  per-host clock and clock enable
- host_csb_i, host_csb_en_i  in  NUM_HOSTS*NUM_CS  per-host CSB and CSB enables (host h at slice h)
- host_sd_i, host_sd_en_i  in  NUM_HOSTS*SD_W  per-host data out and output enables
- host_sd_o  out  NUM_HOSTS*SD_W  pad data returned to each host
- host_intr_error_i, host_intr_event_i, host_rx_valid_i, host_tx_ready_i  in  NUM_HOSTS  per-host strobes
- spi_sck_o, spi_sck_en_o  out  1  pad clock and enable
- spi_csb_o, spi_csb_en_o  out  NUM_CS  pad CSB and enables
- spi_sd_o, spi_sd_en_o  out  SD_W  pad data and enables
- spi_sd_i  in  SD_W  pad data in
- intr_error_o, intr_event_o, rx_valid_o, tx_ready_o  out  1  strobes of the owning host

## Operation
- States: ACTIVE, DRAIN, PARK. Registers: state, active_idx, target_idx, idle counter of width $clog2(IDLE_CYCLES+1), switch_done flag.
- ACTIVE:
  - Pads and strobes are driven combinationally by host active_idx. sel_ready_o=1.
  - Accepted request with idx >= NUM_HOSTS: sel_err_o pulses next cycle; state unchanged.
  - Accepted request with idx == active_idx: no-op, no pulses.
  - Any other accepted request: target_idx <= idx, counter <= 0, go to DRAIN.
- DRAIN:
  - Active host still drives the pads. sel_ready_o=0; requests are ignored without an error pulse.
  - Bus idle means every bit of the active host's CSB slice is 1. Each idle cycle increments the counter; a non-idle cycle clears it to 0.
  - When the counter equals IDLE_CYCLES-1 and the current cycle is idle, go to PARK.
- PARK, exactly 1 cycle:
  - Pads: sck=0, sck_en=1, csb all 1, csb_en all 1, sd 0, sd_en 0.
  - All four output strobes are 0.
  - Next state ACTIVE with active_idx <= target_idx and switch_done flag set.
- host_sd_o: the slice of host active_idx equals spi_sd_i in ACTIVE and DRAIN. All other slices are 0 at all times, and all slices are 0 in PARK.
- Strobes from non-owning hosts are dropped, not queued.

## Timing
- Reset values after rst_i:
  - state ACTIVE, active_idx RESET_HOST, counter 0, target_idx RESET_HOST.
  - sel_ready_o 1, sel_err_o 0, switching_o 0, switch_done_o 0.
  - Pad, strobe and host_sd_o outputs are combinational pass-through of RESET_HOST.
- Pad path latency is 0 cycles (combinational mux). Control outputs are registered-state decodes.
- Handover latency, with the request accepted at cycle T and the bus idle from T+1:
  - DRAIN occupies T+1..T+IDLE_CYCLES.
  - PARK at T+IDLE_CYCLES+1.
  - New host owns the pads, and switch_done_o=1, at T+IDLE_CYCLES+2.
- A CSB falling edge in DRAIN restarts the guard, so handover never cuts a transaction.
- rst_i asserted in any state returns to the reset values on the next edge; a pending target is discarded.

## Test plan
- Reset, NUM_HOSTS=2, RESET_HOST=0 -> active_idx_o=0; spi_sck_o follows host 0; host_sd_o[7:4]=0.
- Bus idle, request idx 1 at cycle 10, IDLE_CYCLES=4 -> switching_o=1 on cycles 11..15; park values on cycle 15; active_idx_o=1 and switch_done_o=1 on cycle 16.
- Host 0 holds csb=2'b10 for 6 cycles after the request -> PARK comes 4 cycles after CSB returns to 2'b11, never earlier.
- Request idx 3 with NUM_HOSTS=3 -> sel_err_o pulses once; active_idx_o unchanged. Request idx == active -> no pulses.
- New request during DRAIN -> sel_ready_o=0; original target still applied.
- rst_i pulse in DRAIN -> next cycle state ACTIVE, active_idx_o=RESET_HOST, switching_o=0; strobes of host 1 do not reach intr_event_o.

Source files
------------

// File: rtl/spi_host_arbiter.sv
// N-way SPI pad arbiter: one host owns the flash pads; ownership moves only after the
// owner's chip selects have been idle for IDLE_CYCLES, followed by a single park cycle.
module spi_host_arbiter #(
  parameter int NUM_HOSTS   = 2,
  parameter int NUM_CS      = 2,
  parameter int SD_W        = 4,
  parameter int IDLE_CYCLES = 4,
  parameter int RESET_HOST  = 0,
  parameter int IDX_W       = $clog2(NUM_HOSTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      sel_valid_i,
  input  logic [IDX_W-1:0]          sel_idx_i,
  output logic                      sel_ready_o,
  output logic                      sel_err_o,
  output logic [IDX_W-1:0]          active_idx_o,
  output logic                      switching_o,
  output logic                      switch_done_o,
  input  logic [NUM_HOSTS-1:0]      host_sck_i,
  input  logic [NUM_HOSTS-1:0]      host_sck_en_i,
  input  logic [NUM_HOSTS*NUM_CS-1:0] host_csb_i,
  input  logic [NUM_HOSTS*NUM_CS-1:0] host_csb_en_i,
  input  logic [NUM_HOSTS*SD_W-1:0] host_sd_i,
  input  logic [NUM_HOSTS*SD_W-1:0] host_sd_en_i,
  output logic [NUM_HOSTS*SD_W-1:0] host_sd_o,
  input  logic [NUM_HOSTS-1:0]      host_intr_error_i,
  input  logic [NUM_HOSTS-1:0]      host_intr_event_i,
  input  logic [NUM_HOSTS-1:0]      host_rx_valid_i,
  input  logic [NUM_HOSTS-1:0]      host_tx_ready_i,
  output logic                      spi_sck_o,
  output logic                      spi_sck_en_o,
  output logic [NUM_CS-1:0]         spi_csb_o,
  output logic [NUM_CS-1:0]         spi_csb_en_o,
  output logic [SD_W-1:0]           spi_sd_o,
  output logic [SD_W-1:0]           spi_sd_en_o,
  input  logic [SD_W-1:0]           spi_sd_i,
  output logic                      intr_error_o,
  output logic                      intr_event_o,
  output logic                      rx_valid_o,
  output logic                      tx_ready_o
);

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] RESET_IDX  = IDX_W'(RESET_HOST);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [IDX_W:0]   HOST_LIMIT = (IDX_W + 1)'(NUM_HOSTS);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_PARK   = 2'd2
  } state_e;

  state_e           state_reg, state_next;
  logic [IDX_W-1:0] active_idx_reg, active_idx_next;
  logic [IDX_W-1:0] target_idx_reg, target_idx_next;
  logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic             switch_done_reg, switch_done_next;
  logic             sel_err_reg, sel_err_next;

  logic [NUM_CS-1:0] csb_arr    [NUM_HOSTS];
  logic [NUM_CS-1:0] csb_en_arr [NUM_HOSTS];
  logic [SD_W-1:0]   sd_arr     [NUM_HOSTS];
  logic [SD_W-1:0]   sd_en_arr  [NUM_HOSTS];

  logic bus_idle;
  logic req_bad;

  for (genvar gi = 0; gi < NUM_HOSTS; gi++) begin : g_host
    assign csb_arr[gi]    = host_csb_i[gi*NUM_CS +: NUM_CS];
    assign csb_en_arr[gi] = host_csb_en_i[gi*NUM_CS +: NUM_CS];
    assign sd_arr[gi]     = host_sd_i[gi*SD_W +: SD_W];
    assign sd_en_arr[gi]  = host_sd_en_i[gi*SD_W +: SD_W];
    // Only the owner sees pad data, and nobody does while the pads are parked.
    assign host_sd_o[gi*SD_W +: SD_W] =
      (state_reg != ST_PARK && active_idx_reg == IDX_W'(gi)) ? spi_sd_i : '0;
  end

  assign bus_idle = &csb_arr[active_idx_reg];
  assign req_bad  = {1'b0, sel_idx_i} >= HOST_LIMIT;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_ACTIVE;
      active_idx_reg  <= RESET_IDX;
      target_idx_reg  <= RESET_IDX;
      idle_cnt_reg    <= '0;
      switch_done_reg <= 1'b0;
      sel_err_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      active_idx_reg  <= active_idx_next;
      target_idx_reg  <= target_idx_next;
      idle_cnt_reg    <= idle_cnt_next;
      switch_done_reg <= switch_done_next;
      sel_err_reg     <= sel_err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    active_idx_next  = active_idx_reg;
    target_idx_next  = target_idx_reg;
    idle_cnt_next    = idle_cnt_reg;
    switch_done_next = 1'b0;
    sel_err_next     = 1'b0;
    case (state_reg)
      ST_ACTIVE: begin
        if (sel_valid_i) begin
          if (req_bad) begin
            sel_err_next = 1'b1;
          end else if (sel_idx_i != active_idx_reg) begin
            target_idx_next = sel_idx_i;
            idle_cnt_next   = '0;
            state_next      = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Any chip-select activity restarts the guard so a transfer is never cut.
        if (!bus_idle) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == CNT_LAST) begin
          state_next = ST_PARK;
        end else begin
          idle_cnt_next = idle_cnt_reg + CNT_W'(1);
        end
      end
      ST_PARK: begin
        state_next       = ST_ACTIVE;
        active_idx_next  = target_idx_reg;
        switch_done_next = 1'b1;
      end
      default: state_next = ST_ACTIVE;
    endcase
  end

  always_comb begin
    sel_ready_o  = (state_reg == ST_ACTIVE);
    switching_o  = (state_reg != ST_ACTIVE);
    spi_sck_o    = host_sck_i[active_idx_reg];
    spi_sck_en_o = host_sck_en_i[active_idx_reg];
    spi_csb_o    = csb_arr[active_idx_reg];
    spi_csb_en_o = csb_en_arr[active_idx_reg];
    spi_sd_o     = sd_arr[active_idx_reg];
    spi_sd_en_o  = sd_en_arr[active_idx_reg];
    intr_error_o = host_intr_error_i[active_idx_reg];
    intr_event_o = host_intr_event_i[active_idx_reg];
    rx_valid_o   = host_rx_valid_i[active_idx_reg];
    tx_ready_o   = host_tx_ready_i[active_idx_reg];
    if (state_reg == ST_PARK) begin
      spi_sck_o    = 1'b0;
      spi_sck_en_o = 1'b1;
      spi_csb_o    = '1;
      spi_csb_en_o = '1;
      spi_sd_o     = '0;
      spi_sd_en_o  = '0;
      intr_error_o = 1'b0;
      intr_event_o = 1'b0;
      rx_valid_o   = 1'b0;
      tx_ready_o   = 1'b0;
    end
  end

  assign active_idx_o  = active_idx_reg;
  assign sel_err_o     = sel_err_reg;
  assign switch_done_o = switch_done_reg;

endmodule

// File: tb/tb_spi_host_arbiter.sv
// Bench for spi_host_arbiter: randomized pad traffic checked each cycle against a
// timeline model (owner, pending handover, last busy cycle, scheduled pulses).
module tb_spi_host_arbiter;
  localparam int NH = 3;
  localparam int NC = 2;
  localparam int SW = 4;
  localparam int IC = 4;
  localparam int RH = 0;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              sel_valid;
  logic [IW-1:0]     sel_idx;
  logic              sel_ready, sel_err, switching, switch_done;
  logic [IW-1:0]     active_idx;
  logic [NH-1:0]     host_sck, host_sck_en;
  logic [NH*NC-1:0]  host_csb, host_csb_en;
  logic [NH*SW-1:0]  host_sd, host_sd_en, host_sd_ret;
  logic [NH-1:0]     h_err, h_evt, h_rxv, h_txr;
  logic              spi_sck, spi_sck_en;
  logic [NC-1:0]     spi_csb, spi_csb_en;
  logic [SW-1:0]     spi_sd, spi_sd_en, spi_sd_in;
  logic              intr_error, intr_event, rx_valid, tx_ready;

  spi_host_arbiter #(
    .NUM_HOSTS(NH), .NUM_CS(NC), .SD_W(SW), .IDLE_CYCLES(IC), .RESET_HOST(RH)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .sel_valid_i(sel_valid), .sel_idx_i(sel_idx), .sel_ready_o(sel_ready),
    .sel_err_o(sel_err), .active_idx_o(active_idx), .switching_o(switching),
    .switch_done_o(switch_done),
    .host_sck_i(host_sck), .host_sck_en_i(host_sck_en),
    .host_csb_i(host_csb), .host_csb_en_i(host_csb_en),
    .host_sd_i(host_sd), .host_sd_en_i(host_sd_en), .host_sd_o(host_sd_ret),
    .host_intr_error_i(h_err), .host_intr_event_i(h_evt),
    .host_rx_valid_i(h_rxv), .host_tx_ready_i(h_txr),
    .spi_sck_o(spi_sck), .spi_sck_en_o(spi_sck_en),
    .spi_csb_o(spi_csb), .spi_csb_en_o(spi_csb_en),
    .spi_sd_o(spi_sd), .spi_sd_en_o(spi_sd_en), .spi_sd_i(spi_sd_in),
    .intr_error_o(intr_error), .intr_event_o(intr_event),
    .rx_valid_o(rx_valid), .tx_ready_o(tx_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Timeline model: a handover accepted at m_t parks IC+1 cycles after the last busy cycle.
  int m_owner, m_target, m_t, m_last_busy, m_err_at, m_done_at;
  bit m_pending;
  bit force_busy;
  logic [NC-1:0] busy_csb;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = RH; m_target = RH; m_pending = 0;
    m_t = -100; m_last_busy = -100; m_err_at = -1; m_done_at = -1;
  endtask

  task automatic drive_rand();
    host_sck    = NH'($urandom);
    host_sck_en = NH'($urandom);
    host_csb    = (NH*NC)'($urandom);
    host_csb_en = (NH*NC)'($urandom);
    host_sd     = (NH*SW)'($urandom);
    host_sd_en  = (NH*SW)'($urandom);
    spi_sd_in   = SW'($urandom);
    h_err = NH'($urandom); h_evt = NH'($urandom);
    h_rxv = NH'($urandom); h_txr = NH'($urandom);
    host_csb[m_owner*NC +: NC] = force_busy ? busy_csb : '1;
  endtask

  task automatic check_cycle();
    bit drain, park, ready;
    logic [NH*SW-1:0] exp_ret;
    drain = 0; park = 0;
    if (m_pending && cyc > m_t) begin
      if (cyc == m_last_busy + IC + 1) park = 1;
      else begin
        drain = 1;
        if (!(&host_csb[m_owner*NC +: NC])) m_last_busy = cyc;
      end
    end
    ready = !(drain || park);
    exp_ret = '0;
    if (!park) exp_ret[m_owner*SW +: SW] = spi_sd_in;

    chk("sel_ready", sel_ready, ready);
    chk("switching", switching, !ready);
    chk("sel_err", sel_err, cyc == m_err_at);
    chk("switch_done", switch_done, cyc == m_done_at);
    chk("active_idx", active_idx, m_owner);
    chk("host_sd_o", host_sd_ret, exp_ret);
    chk("sck", spi_sck, park ? 1'b0 : host_sck[m_owner]);
    chk("sck_en", spi_sck_en, park ? 1'b1 : host_sck_en[m_owner]);
    chk("csb", spi_csb, park ? 2'b11 : host_csb[m_owner*NC +: NC]);
    chk("csb_en", spi_csb_en, park ? 2'b11 : host_csb_en[m_owner*NC +: NC]);
    chk("sd", spi_sd, park ? 4'h0 : host_sd[m_owner*SW +: SW]);
    chk("sd_en", spi_sd_en, park ? 4'h0 : host_sd_en[m_owner*SW +: SW]);
    chk("intr_error", intr_error, park ? 1'b0 : h_err[m_owner]);
    chk("intr_event", intr_event, park ? 1'b0 : h_evt[m_owner]);
    chk("rx_valid", rx_valid, park ? 1'b0 : h_rxv[m_owner]);
    chk("tx_ready", tx_ready, park ? 1'b0 : h_txr[m_owner]);

    if (park) begin
      m_owner = m_target; m_pending = 0; m_done_at = cyc + 1;
    end
    if (ready && sel_valid) begin
      if (int'(sel_idx) >= NH) m_err_at = cyc + 1;
      else if (int'(sel_idx) != m_owner) begin
        m_pending = 1; m_t = cyc; m_last_busy = cyc; m_target = int'(sel_idx);
      end
    end
  endtask

  task automatic tick(bit do_check = 1'b1);
    drive_rand();
    #2;
    if (do_check) check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic request(int idx);
    sel_valid = 1'b1; sel_idx = IW'(idx);
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sel_valid = 1'b0;
    tick(1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; sel_valid = 1'b0; sel_idx = '0; force_busy = 0; busy_csb = '1;
    model_reset();
    tick(1'b0);
    do_reset();
    // Pass-through from the reset host.
    repeat (3) tick();
    // Idle-bus handover to host 1 with a stray request during DRAIN.
    request(1);
    tick();
    sel_valid = 1'b1; sel_idx = 2'd2;
    tick();
    sel_valid = 1'b0;
    repeat (6) tick();
    // Busy chip select holds off the handover back to host 0.
    request(0);
    force_busy = 1; busy_csb = 2'b10;
    repeat (6) tick();
    force_busy = 0;
    repeat (7) tick();
    // Out-of-range index and self-request.
    request(3);
    repeat (2) tick();
    request(0);
    repeat (2) tick();
    // Reset in the middle of a drain discards the target.
    request(2);
    repeat (2) tick();
    do_reset();
    repeat (3) tick();
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      sel_valid = ($urandom_range(0, 3) == 0);
      sel_idx   = IW'($urandom_range(0, 3));
      force_busy = ($urandom_range(0, 2) == 0);
      busy_csb  = NC'($urandom);
      tick();
    end
    sel_valid = 1'b0; force_busy = 0;
    repeat (8) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
